// File: rtl/rf_wb_arbiter_pkg.sv
// Shared write-back arbiter types and defaults.
// Requester indices and default datapath widths.
package rf_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_LSU = 2'd1,
    WB_SRC_MUL = 2'd2,
    WB_SRC_CSR = 2'd3
  } wb_src_e;

  localparam int WB_ADDR_W = 4;
  localparam int WB_DATA_W = 16;

endpackage

// File: rtl/rf_wb_arbiter_dec.sv
// Address to one-hot word-line decoder.
// Output is all zeros when the enable is low.
module decoder4to16 #(
  parameter int ip_L = 4
) (
  input  logic [ip_L-1:0]      i_addr,
  input  logic                 i_en,
  output logic [(2**ip_L)-1:0] o_dec
);

  always_comb begin
    o_dec = '0;
    if (i_en) o_dec[i_addr] = 1'b1;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter onto the single
// register-file write port, with registered output stage.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int ADDR_W  = WB_ADDR_W,
  parameter  int DATA_W  = WB_DATA_W,
  parameter  bit ZERO_RO = 1'b1,
  localparam int SRC_W   = $clog2(NREQ),
  localparam int NREG    = 2**ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   rf_stall,
  output logic                   wb_valid,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [NREG-1:0]        wb_we,
  output logic [SRC_W-1:0]       wb_src,
  output logic [7:0]             conflict_cnt
);

  localparam logic [SRC_W:0] NREQ_X = (SRC_W+1)'(NREQ);

  logic [SRC_W-1:0]  r_ptr;
  logic [SRC_W-1:0]  r_src;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [NREG-1:0]   r_we;
  logic [7:0]        r_cnt;

  logic              w_found;
  logic [SRC_W-1:0]  w_idx;
  logic [SRC_W:0]    w_sum;
  logic              w_gnt;
  logic              w_multi;
  logic              w_we_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [NREG-1:0]   w_we;

  // Scan from r_ptr upward, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    for (int off = 0; off < NREQ; off++) begin
      w_sum = {1'b0, r_ptr} + (SRC_W+1)'(off);
      if (w_sum >= NREQ_X) w_sum = w_sum - NREQ_X;
      if (!w_found && req_valid[w_sum[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == SRC_W'(i)) begin
        w_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_gnt     = w_found & ~rf_stall & ~rst;
  assign req_ready = w_gnt ? (NREQ'(1) << w_idx) : '0;
  assign w_multi   = |(req_valid & (req_valid - NREQ'(1)));
  // Register 0 writes complete the handshake but drive no word line.
  assign w_we_en   = w_gnt & ~(ZERO_RO & (w_addr == '0));

  decoder4to16 #(
    .ip_L (ADDR_W)
  ) u_dec (
    .i_addr (w_addr),
    .i_en   (w_we_en),
    .o_dec  (w_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else if (!rf_stall) begin
      r_valid <= w_gnt;
      r_we    <= w_we;
      if (w_gnt) begin
        r_addr <= w_addr;
        r_data <= w_data;
        r_src  <= w_idx;
        r_ptr  <= (w_idx == SRC_W'(NREQ-1)) ? '0
                : w_idx + SRC_W'(1);
        if (w_multi && r_cnt != 8'hFF)
          r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign wb_valid     = r_valid;
  assign wb_addr      = r_addr;
  assign wb_data      = r_data;
  assign wb_we        = r_we;
  assign wb_src       = r_src;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed plus random bench for rf_wb_arbiter.
// Expected values come from a reference model of the arbitration rules.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        rf_stall;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] wb_we;
  logic [1:0]  wb_src;
  logic [7:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  logic        m_valid;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] m_we;
  int          m_src;
  int          m_cnt;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NREQ    (4),
    .ADDR_W  (4),
    .DATA_W  (16),
    .ZERO_RO (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rf_stall     (rf_stall),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_we        (wb_we),
    .wb_src       (wb_src),
    .conflict_cnt (conflict_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First valid requester at or after ptr, modulo 4; -1 if none.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int o = 0; o < 4; o++)
      if (v[(p + o) % 4]) return (p + o) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_addr = '0;
    m_data = '0; m_we = '0; m_src = 0; m_cnt = 0;
  endtask

  // One cycle: drive, check ready, clock, update model, check outputs.
  task automatic step(input logic r, input logic [3:0] v,
                      input logic [15:0] a, input logic [63:0] d,
                      input logic s, input string tag);
    int g;
    logic [3:0] e_rdy;
    rst = r; req_valid = v; req_addr = a; req_data = d; rf_stall = s;
    g = pick(v, m_ptr);
    e_rdy = (r || s || g < 0) ? 4'b0 : (4'b1 << g);
    #1;
    chk({tag, ":ready"}, 64'(req_ready), 64'(e_rdy));
    @(posedge clk);
    if (r) model_reset();
    else if (!s) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_addr  = a[g*4 +: 4];
        m_data  = d[g*16 +: 16];
        m_we    = (m_addr == 0) ? 16'h0 : (16'h1 << m_addr);
        m_src   = g;
        m_ptr   = (g + 1) % 4;
        if ($countones(v) >= 2 && m_cnt < 255) m_cnt++;
      end else begin
        m_valid = 1'b0;
        m_we    = '0;
      end
    end
    #1;
    chk({tag, ":valid"}, 64'(wb_valid), 64'(m_valid));
    chk({tag, ":addr"},  64'(wb_addr),  64'(m_addr));
    chk({tag, ":data"},  64'(wb_data),  64'(m_data));
    chk({tag, ":we"},    64'(wb_we),    64'(m_we));
    chk({tag, ":src"},   64'(wb_src),   64'(m_src));
    chk({tag, ":cnt"},   64'(conflict_cnt), 64'(m_cnt));
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    rst = 1'b1; req_valid = '0; req_addr = '0;
    req_data = '0; rf_stall = 1'b0;
    model_reset();
    @(negedge clk);

    a = {4'd4, 4'd3, 4'd2, 4'd1};
    d = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, a, d, 1'b0, "reset");
    chk("reset_cnt", 64'(conflict_cnt), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 4'hF, a, d, 1'b0, "rr");
    chk("rr_cnt5", 64'(conflict_cnt), 64'd5);
    chk("rr_last_src", 64'(wb_src), 64'd0);

    step(1'b1, 4'h0, '0, '0, 1'b0, "rst2");
    a = {4'd0, 4'd0, 4'd5, 4'd0};
    d = {16'h0, 16'h0, 16'hBEEF, 16'h0};
    step(1'b0, 4'b0010, a, d, 1'b0, "single");
    chk("single_we", 64'(wb_we), 64'h0020);
    chk("single_data", 64'(wb_data), 64'hBEEF);

    a = {4'd0, 4'd7, 4'd0, 4'd0};
    d = {16'h1234, 16'h7777, 16'h0, 16'h0};
    step(1'b0, 4'b0100, a, d, 1'b0, "pre_stall");
    for (int i = 0; i < 3; i++) step(1'b0, 4'hF, a, d, 1'b1, "stall");
    chk("stall_we", 64'(wb_we), 64'h0080);
    step(1'b0, 4'hF, a, d, 1'b0, "reg0");
    chk("reg0_src", 64'(wb_src), 64'd3);
    chk("reg0_we", 64'(wb_we), 64'h0000);
    chk("reg0_valid", 64'(wb_valid), 64'd1);
    step(1'b0, 4'b1001, a, d, 1'b0, "ptr_wrap");
    chk("ptr_wrap_src", 64'(wb_src), 64'd0);

    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      d = {32'($urandom), 32'($urandom)};
      step(($urandom_range(0, 49) == 0), 4'($urandom),
           a, d, ($urandom_range(0, 3) == 0), "rand");
    end

    step(1'b1, 4'h0, '0, '0, 1'b0, "rst3");
    a = {4'd4, 4'd3, 4'd2, 4'd1};
    d = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < 300; i++) step(1'b0, 4'b0011, a, d, 1'b0, "sat");
    chk("sat_cnt", 64'(conflict_cnt), 64'd255);
    step(1'b0, 4'b0011, a, d, 1'b0, "sat_hold");
    chk("sat_hold_cnt", 64'(conflict_cnt), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
